// File: rtl/gcd_engine.sv
// gcd_engine: binary (Stein) GCD engine, one reduction step per clock; GCD_CYCLE_COUNT_EN adds a cycles port
module gcd_engine #(
    parameter int WIDTH = 16,
    localparam int KW = $clog2(WIDTH + 1),
    localparam int CW = $clog2(2 * WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef GCD_CYCLE_COUNT_EN
    output logic [CW-1:0]    cycles,
`endif
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] x, y;
    logic [KW-1:0] k;
    // capture on start, one Stein step per RUN edge, one-cycle DONE back to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef GCD_CYCLE_COUNT_EN
            cycles <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    x    <= a;
                    y    <= b;
                    k    <= '0;
                    busy <= 1'b1;
`ifdef GCD_CYCLE_COUNT_EN
                    cycles <= '0;
`endif
                    if (a == '0 || b == '0) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= a | b;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef GCD_CYCLE_COUNT_EN
                    cycles <= cycles + CW'(1);
`endif
                    if (x == y) begin
                        result <= x << k;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else if (!x[0] && !y[0]) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + KW'(1);
                    end else if (!x[0]) begin
                        x <= x >> 1;
                    end else if (!y[0]) begin
                        y <= y >> 1;
                    end else if (x > y) begin
                        x <= (x - y) >> 1;
                    end else begin
                        y <= (y - x) >> 1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed checks of gcd_engine at WIDTH=16 plus an exhaustive 4-bit sweep at WIDTH=8
module tb_gcd_engine;
    logic        clk;
    logic        reset;
    logic        start, start8;
    logic [15:0] a, b, result;
    logic [7:0]  a8, b8, result8;
    logic        busy, done, busy8, done8;
`ifdef GCD_CYCLE_COUNT_EN
    logic [5:0]  cycles;
    logic [4:0]  cycles8;
`endif
    int checks = 0;
    int errors = 0;

    gcd_engine #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done),
`ifdef GCD_CYCLE_COUNT_EN
        .cycles(cycles),
`endif
        .result(result)
    );

    gcd_engine #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8),
`ifdef GCD_CYCLE_COUNT_EN
        .cycles(cycles8),
`endif
        .result(result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd(input int p, input int q);
        int t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // ee = clock edges from the capture edge (inclusive) until done is seen high
    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] er,
                         input int ee, input string tag);
        int n;
        a = av;
        b = bv;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            tick;
            n++;
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " edges"}, n, ee);
        chk({tag, " result"}, {16'd0, result}, {16'd0, er});
`ifdef GCD_CYCLE_COUNT_EN
        chk({tag, " cycles"}, {26'd0, cycles}, (ee == 1) ? 32'd0 : ee - 1);
`endif
        tick;
        chk({tag, " done width"}, {31'd0, done}, 32'd0);
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
        chk({tag, " held"}, {16'd0, result}, {16'd0, er});
    endtask

    initial begin
        int n;
        logic [7:0] pr;
        reset = 1'b1;
        start = 1'b0;
        start8 = 1'b0;
        a = '0;
        b = '0;
        a8 = '0;
        b8 = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", {16'd0, result}, 32'd0);
        tick;
        tick;
        reset = 1'b1;

        run16(16'd12, 16'd18, 16'd6, 5, "12_18");
        run16(16'd0, 16'd7, 16'd7, 1, "0_7");
        run16(16'd0, 16'd0, 16'd0, 1, "0_0");
        run16(16'd65535, 16'd65535, 16'd65535, 2, "max_max");
        run16(16'd65535, 16'd1, 16'd1, 17, "max_1");
        run16(16'd0, 16'd7, 16'd7, 1, "0_7b");

        a = 16'd12;
        b = 16'd18;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("ign busy e1", {31'd0, busy}, 32'd1);
        tick;
        chk("ign busy e2", {31'd0, busy}, 32'd1);
        a = 16'd9;
        b = 16'd6;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 3;
        chk("ign busy e3", {31'd0, busy}, 32'd1);
        while (!done && n < 40) begin
            tick;
            n++;
            chk("ign busy run", {31'd0, busy}, 32'd1);
        end
        chk("ign edges", n, 5);
        chk("ign result", {16'd0, result}, 32'd6);
        tick;
        chk("ign idle", {31'd0, busy}, 32'd0);
        tick;
        chk("ign no queue", {31'd0, busy}, 32'd0);
        chk("ign held", {16'd0, result}, 32'd6);

        a = 16'd48;
        b = 16'd36;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("mid busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst done", {31'd0, done}, 32'd0);
        chk("arst result", {16'd0, result}, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("arst cycles", {26'd0, cycles}, 32'd0);
`endif
        tick;
        reset = 1'b1;
        run16(16'd48, 16'd36, 16'd12, 7, "48_36");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a8 = i[7:0];
                b8 = j[7:0];
                pr = result8;
                start8 = 1'b1;
                tick;
                start8 = 1'b0;
                n = 1;
                while (!done8 && n < 40) begin
                    chk("sweep hold", {24'd0, result8}, {24'd0, pr});
                    tick;
                    n++;
                end
                chk("sweep done", {31'd0, done8}, 32'd1);
                chk("sweep gcd", {24'd0, result8}, gcd(i, j));
                pr = result8;
                tick;
                chk("sweep pulse", {31'd0, done8}, 32'd0);
                chk("sweep held", {24'd0, result8}, {24'd0, pr});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have derived localparam KW = $clog2(WIDTH+1), the width of the common-factor shift counter.
REQ-003 The block SHALL have derived localparam CW = $clog2(2*WIDTH+2), the width of the iteration counter.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 The block SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 The block SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port result  output  WIDTH  GCD of the last completed operation; held between operations.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE; done SHALL equal (state==DONE), and busy SHALL equal (state!=IDLE).
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL capture x<=a, y<=b and k<=0.
REQ-014 At that same capture edge, if a==0 or b==0, the block SHALL go directly to DONE with result<=a|b, so that gcd(0,0)=0.
REQ-015 At that same capture edge, if both a and b are nonzero, the block SHALL go to RUN.
REQ-016 Each RUN edge SHALL perform exactly one step, in this priority order:
  x==y: result<=x<<k, go to DONE.
  x and y both even: x>>=1, y>>=1, k++.
  x even only: x>>=1.
  y even only: y>>=1.
  both odd, x>y: x<=(x-y)>>1.
  both odd, otherwise: y<=(y-x)>>1.
REQ-017 Subtraction SHALL be WIDTH-bit unsigned, x<<k SHALL be truncated to WIDTH bits, and k SHALL never exceed WIDTH-1.
REQ-018 The block SHALL leave DONE for IDLE unconditionally after one cycle, so that done is exactly one cycle wide.
REQ-019 The block SHALL ignore start in RUN and DONE, with no queuing; a start held high through DONE SHALL begin a new operation on the first IDLE edge.
REQ-020 The block SHALL ignore a and b except at the capture edge, and operand changes during RUN SHALL have no effect.
REQ-021 result SHALL change only on entry to DONE and SHALL otherwise hold its value.
REQ-022 Latency from the capture edge to done high SHALL be (number of RUN steps) cycles, with a minimum of 1 for the zero-operand path; the worst case is at most 2*WIDTH+1 RUN steps.

Reset
REQ-023 reset=0 SHALL asynchronously force state=IDLE and x=y=k=0.
REQ-024 reset=0 SHALL asynchronously force result=0, done=0 and busy=0, including mid-RUN, with the in-flight operation discarded.
REQ-025 After reset deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-026 With the macro GCD_CYCLE_COUNT_EN defined, the block SHALL add output port cycles [CW-1:0].
REQ-027 With GCD_CYCLE_COUNT_EN defined, cycles SHALL be cleared at the capture edge and incremented on every RUN edge.
REQ-028 With GCD_CYCLE_COUNT_EN defined, cycles SHALL hold its value from DONE until the next capture, be 0 for the zero-operand path, and reset to 0.
REQ-029 Without GCD_CYCLE_COUNT_EN, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-030 The bench SHALL cover a=12, b=18, WIDTH=16 -> 4 RUN steps (6,9,k=1 ; 3,9 ; 3,3 ; equal), done high in the 4th cycle after capture, result=6, cycles=4.
REQ-031 The bench SHALL cover a=0, b=7 -> DONE directly, done high in the 1st cycle after capture, result=7, cycles=0; then a=0, b=0 -> result=0.
REQ-032 The bench SHALL cover a=b=65535 -> 1 RUN step, result=65535; then a=65535, b=1 -> result=1, with done asserted within 33 cycles.
REQ-033 The bench SHALL cover start for (12,18) followed by start pulsed 2 cycles later with (9,6) -> second request ignored, result=6, and busy continuously high from the capture edge until DONE exits.
REQ-034 The bench SHALL cover reset driven low mid-RUN of (48,36) -> busy, done and result read 0 before the next edge; after release, (48,36) -> result=12.
REQ-035 The bench SHALL cover an exhaustive sweep of a,b in 0..15 at WIDTH=8 against a software GCD, checking that done is never high for two consecutive cycles and that result never changes outside DONE entry.
